// File: rtl/life_grid_loader.sv
`default_nettype none
// ============================================================================
//  Module   : life_grid_loader
//  Purpose  : Accepts an 8x8 life grid as eight row bytes over valid/ready,
//             assembles the four 4x4 tile words and writes them into the
//             life array through vali / vali_selector / write_enb.
//             Optional macro LOADER_READBACK_EN builds a readback pass that
//             reads every tile back through valo_selector / valo and sets a
//             sticky error flag on mismatch.
//  Revision : 1.0 - initial release
// ============================================================================
module life_grid_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  row_data,
  input  logic        row_valid,
  output logic        row_ready,
  output logic [15:0] vali,
  output logic [1:0]  vali_selector,
  output logic        write_enb,
  input  logic [15:0] valo,
  output logic [1:0]  valo_selector,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_WRITE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_row_cnt;
  logic [1:0]  r_tile_cnt;
  logic [15:0] r_tile     [4];
  logic [15:0] w_tile_nxt [4];
  logic        w_accept;
  logic        w_last_row;
  logic [2:0]  w_col;
  logic        w_wr_nxt;
  logic [1:0]  w_wr_idx;
  logic        r_write_enb;
  logic [1:0]  r_vali_selector;
  logic [15:0] r_vali;

  assign row_ready  = (r_state == S_FILL);
  assign busy       = (r_state != S_FILL);
  assign done       = (r_state == S_DONE);
  assign w_accept   = row_valid & row_ready;
  assign w_last_row = (r_row_cnt == 3'd7);

  assign write_enb     = r_write_enb;
  assign vali_selector = r_vali_selector;
  assign vali          = r_vali;

  // Next-state logic for the fill / write / verify / done sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept && w_last_row) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (r_tile_cnt == 2'd3) begin
`ifdef LOADER_READBACK_EN
          w_state_nxt = S_VERIFY;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
      S_VERIFY: begin
`ifdef LOADER_READBACK_EN
        if (r_tile_cnt == 2'd3) w_state_nxt = S_DONE;
`else
        w_state_nxt = S_FILL;
`endif
      end
      S_DONE:  w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  // Scatter an accepted row into its two tiles; row 0 starts a fresh frame
  always_comb begin
    w_col = 3'd0;
    for (int k = 0; k < 4; k++) w_tile_nxt[k] = r_tile[k];
    if (w_accept) begin
      if (r_row_cnt == 3'd0) begin
        for (int k = 0; k < 4; k++) w_tile_nxt[k] = 16'h0000;
      end
      // tile = {col[2], row[2]}, bit = {col[1:0], row[1:0]}
      for (int c = 0; c < 8; c++) begin
        w_col = 3'(c);
        w_tile_nxt[{w_col[2], r_row_cnt[2]}][{w_col[1:0], r_row_cnt[1:0]}] = row_data[c];
      end
    end
  end

  // Row counter, tile counter and tile storage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_cnt  <= 3'd0;
      r_tile_cnt <= 2'd0;
      for (int k = 0; k < 4; k++) r_tile[k] <= 16'h0000;
    end else begin
      for (int k = 0; k < 4; k++) r_tile[k] <= w_tile_nxt[k];
      if (w_accept)              r_row_cnt <= r_row_cnt + 3'd1;
      else if (r_state == S_DONE) r_row_cnt <= 3'd0;
      // Tile counter walks 0..3 through WRITE and again through VERIFY
      if (r_state == S_WRITE || r_state == S_VERIFY) r_tile_cnt <= r_tile_cnt + 2'd1;
      else                                           r_tile_cnt <= 2'd0;
    end
  end

  // Tile presented on the write port in the coming cycle
  assign w_wr_nxt = (w_state_nxt == S_WRITE);
  assign w_wr_idx = (r_state == S_WRITE) ? (r_tile_cnt + 2'd1) : 2'd0;

  // Registered write port: loaded one edge ahead so tile k shows in WRITE cycle k
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_enb     <= 1'b0;
      r_vali_selector <= 2'd0;
      r_vali          <= 16'h0000;
    end else begin
      r_write_enb     <= w_wr_nxt;
      r_vali_selector <= w_wr_nxt ? w_wr_idx : 2'd0;
      r_vali          <= w_wr_nxt ? w_tile_nxt[w_wr_idx] : 16'h0000;
    end
  end

`ifdef LOADER_READBACK_EN
  logic r_error;
  logic w_verify;
  logic w_mismatch;

  assign w_verify      = (r_state == S_VERIFY);
  assign valo_selector = w_verify ? r_tile_cnt : 2'd0;
  assign w_mismatch    = w_verify && (valo != r_tile[r_tile_cnt]);
  // The flag rises in the very cycle the bad tile is read, then stays sticky
  assign error         = r_error | w_mismatch;

  // Sticky readback error, cleared when the next frame starts
  always_ff @(posedge clk) begin
    if (reset)                               r_error <= 1'b0;
    else if (w_accept && r_row_cnt == 3'd0)  r_error <= 1'b0;
    else if (w_mismatch)                     r_error <= 1'b1;
  end
`else
  logic w_unused_valo;

  assign valo_selector = 2'd0;
  assign error         = 1'b0;
  assign w_unused_valo = ^valo;
`endif

endmodule
`default_nettype wire
